// File: rtl/fft_polyphase_reorder.sv
// fft_polyphase_reorder
// Ping-pong frame buffer that takes complex samples in natural order and
// replays each frame as D = 2^LOG2_DECIM decimated sub-streams:
// all indices 0 mod D first, then 1 mod D, and so on up to D-1 mod D.
// Data passes bit-exact. Ready/valid flow control is used on both sides.
module fft_polyphase_reorder #(
  parameter int LOG2_NFFT     = 6,
  parameter int LOG2_DECIM    = 1,
  parameter int DATA_FFT_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_FFT_SIZE-1:0] in_data_i,
  input  logic [DATA_FFT_SIZE-1:0] in_data_q,
  input  logic                     valid,
  output logic                     in_ready,
  input  logic                     fft_wayt_data,
  output logic [DATA_FFT_SIZE-1:0] out_data_i,
  output logic [DATA_FFT_SIZE-1:0] out_data_q,
  output logic                     outvalid,
  output logic [LOG2_DECIM-1:0]    out_phase,
  output logic                     out_last_phase,
  output logic                     out_last_frame,
  output logic                     frame_done
);

  localparam int N        = 1 << LOG2_NFFT;
  localparam int LOG2_SUB = LOG2_NFFT - LOG2_DECIM;
  localparam int DW       = 2 * DATA_FFT_SIZE;

  // Both banks share one array; the top address bit selects the bank.
  logic [DW-1:0]        mem [0:2*N-1];

  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic                 iss_bank;
  logic [LOG2_NFFT-1:0] wr_cnt;
  logic [LOG2_NFFT-1:0] iss_k;

  logic                 wr_fire;
  logic                 wr_last;
  logic                 advance;
  logic                 issue;
  logic                 xfer;
  logic                 release_bank;
  logic [LOG2_NFFT:0]   rd_addr;

  assign in_ready     = !full[wr_bank] && !reset;
  assign wr_fire      = valid && in_ready;
  assign wr_last      = wr_fire && (&wr_cnt);

  // The output register may be reloaded when it is empty or being consumed.
  // Loading happens in the same cycle as the transfer, so the next sample
  // is already in flight and the stream has no bubbles.
  assign xfer         = outvalid && fft_wayt_data;
  assign advance      = !outvalid || fft_wayt_data;
  assign issue        = advance && full[iss_bank];
  assign release_bank = xfer && out_last_frame;

  // Output index k = {p, m}. The sample read is x[m*D + p], which is {m, p}.
  assign rd_addr = {iss_bank, iss_k[LOG2_SUB-1:0], iss_k[LOG2_NFFT-1 -: LOG2_DECIM]};

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_cnt}] <= {in_data_i, in_data_q};
    end
  end

  // Registered read into the output stage. This stage holds the sample while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      outvalid       <= 1'b0;
      out_data_i     <= '0;
      out_data_q     <= '0;
      out_phase      <= '0;
      out_last_phase <= 1'b0;
      out_last_frame <= 1'b0;
    end else if (advance) begin
      outvalid <= issue;
      if (issue) begin
        {out_data_i, out_data_q} <= mem[rd_addr];
        out_phase      <= iss_k[LOG2_NFFT-1 -: LOG2_DECIM];
        out_last_phase <= &iss_k[LOG2_SUB-1:0];
        out_last_frame <= &iss_k;
      end
    end
  end

  // Fill and drain pointers, bank full flags and frame completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      iss_bank   <= 1'b0;
      iss_k      <= '0;
      full       <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + LOG2_NFFT'(1);
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (issue) begin
        iss_k <= iss_k + LOG2_NFFT'(1);
        if (&iss_k) iss_bank <= ~iss_bank;
      end
      if (release_bank) rd_bank <= ~rd_bank;
      // Setting and clearing always hit different banks. A bank is only written
      // while not full, and it is only released while full.
      for (int b = 0; b < 2; b++) begin
        if (wr_last && (wr_bank == 1'(b)))
          full[b] <= 1'b1;
        else if (release_bank && (rd_bank == 1'(b)))
          full[b] <= 1'b0;
      end
      frame_done <= release_bank;
    end
  end

endmodule

// File: doc/fft_polyphase_reorder.md
# fft_polyphase_reorder

Frame reorder buffer between the sample source and the FFT core. It accepts complex samples in natural order, N = 2^LOG2_NFFT per frame. It emits each frame as D = 2^LOG2_DECIM decimated sub-streams: all indices ≡0 mod D first, then ≡1 mod D, and so on. It generalises the two-way even/odd split to D ways, with ping-pong frame banks and ready/valid flow control on both sides.

## Interface
- LOG2_NFFT, 6: log2 of frame length N; valid range 2..12
- LOG2_DECIM, 1: log2 of decimation ways D; valid range 1..LOG2_NFFT-1
- DATA_FFT_SIZE, 16: width of each I/Q component
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data_i / in_data_q  in  DATA_FFT_SIZE each  input sample
- valid  in  1  input sample present
- in_ready  out  1  block can accept; sample accepted when valid & in_ready
- fft_wayt_data  in  1  FFT ready; output transferred when outvalid & fft_wayt_data
- out_data_i / out_data_q  out  DATA_FFT_SIZE each  reordered sample
- outvalid  out  1  output sample present
- out_phase  out  LOG2_DECIM  sub-stream index p of current output
- out_last_phase  out  1  last sample of current sub-stream
- out_last_frame  out  1  last sample of frame (p=D-1, last of sub-stream)
- frame_done  out  1  one-cycle pulse the cycle after the last sample of a frame is transferred

## Operation
- Two banks of N×2·DATA_FFT_SIZE storage. Each bank has a full flag. wr_bank is the fill pointer; rd_bank is the drain pointer.
- Write side:
  - wr_cnt (LOG2_NFFT bits) counts accepted samples; the sample is stored at address wr_cnt in wr_bank.
  - On acceptance with wr_cnt = N-1: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - in_ready = !full[wr_bank] & !reset (combinational).
- Read side:
  - Output index k = 0..N-1; p = k >> (LOG2_NFFT-LOG2_DECIM); m = k mod (N/D).
  - Read address = m·D + p, i.e. bit concatenation {m, p}.
  - Output sequence for frame x: x[0], x[D], x[2D], …, x[1], x[1+D], …, x[N-1].
  - out_phase = p. out_last_phase = (m = N/D-1). out_last_frame = (k = N-1).
- Storage uses registered read (block-RAM style). Read logic must prefetch and hold a skid entry so that a stall never loses, duplicates or reorders a sample.
- Bank release: on transfer of k = N-1, clear full[rd_bank], toggle rd_bank, pulse frame_done on the next cycle.
- Outputs hold stable (data, phase, flags) while outvalid & !fft_wayt_data.
- No arithmetic is performed; data passes bit-exact.
- Reset (any time, including mid-frame or mid-drain):
  - discards both banks; clears full flags, wr_cnt and k
  - sets wr_bank = rd_bank = 0
  - drives outvalid, out_data_*, out_phase, out_last_*, frame_done to 0
  - in_ready is 0 while reset is high and 1 on the first cycle after.

## Timing
- Fill latency: let E be the cycle accepting sample N-1. With fft_wayt_data high and the output idle, out sample k=0 is valid at E+2. Sample k is valid at E+2+k (1 sample/cycle, no bubbles).
- Back-to-back frames: if the other bank is full when k=N-1 transfers, k=0 of the next frame is valid on the following cycle.
- Continuous input (valid always 1) with fft_wayt_data always 1: in_ready is low at most 2 cycles per frame. No sample is dropped.
- Simultaneous write of sample N-1 into one bank and transfer of k=N-1 from the other in the same cycle: both take effect; full flags update independently.
- A released bank becomes writable (in_ready=1) the cycle after the release transfer.
- Both banks full: in_ready=0 until a release. Write side holds wr_cnt=0.
- valid while in_ready=0: sample ignored, no state change.

## Test plan
- N=16, D=2, one frame with sample value = index, ready=1 → outputs 0,2,4,…,14,1,3,…,15. out_phase=0 for the first 8 outputs and 1 for the last 8. out_last_phase on 14 and 15; out_last_frame on 15. First output at E+2; frame_done one cycle after 15.
- N=16, D=4, same stimulus → 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. out_last_phase on 12, 13, 14, 15.
- Pseudo-random fft_wayt_data (50%), 4 frames → every frame in the correct order, no duplicates or losses. Outputs are stable during every stall cycle.
- fft_wayt_data=0, 40 continuous input samples → in_ready falls after sample 32 and no further samples are accepted. Then raise ready → frames 0 and 1 emitted in order, in_ready returns, frame 2 completes.
- Continuous input and ready, 3 frames (N=16, D=2) → 48 correct outputs; in_ready low ≤2 cycles per frame boundary.
- Reset asserted at wr_cnt=9 and during drain (k=5), then a fresh frame → no stale samples emitted; all outputs zero during reset; the new frame reorders correctly.
